mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of both requester operands and of the output.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 requests the shared 2:1 path.
REQ-006 req1  input  1  requester 1 requests the shared 2:1 path.
REQ-007 a  input  WIDTH  requester 0 operand.
REQ-008 b  input  WIDTH  requester 1 operand.
REQ-009 gnt0  output  1  requester 0 owns the path (registered).
REQ-010 gnt1  output  1  requester 1 owns the path (registered).
REQ-011 sel  output  1  mux select driven to the 2:1 datapath: 0 = a, 1 = b (registered).
REQ-012 y  output  WIDTH  registered selected operand.
REQ-013 y_valid  output  1  y holds a newly captured operand this cycle.
REQ-014 busy  output  1  high whenever gnt0 or gnt1 is high.

Function
REQ-015 States SHALL be IDLE, G0, G1; gnt0 = (state==G0), gnt1 = (state==G1), busy = gnt0|gnt1.
REQ-016 sel SHALL be 1 in G1, 0 in G0, and hold its last value in IDLE.
REQ-017 A last-served flag SHALL record the most recently granted requester; on reset it indicates requester 1, so requester 0 wins the first tie.
REQ-018 IDLE: req0 only -> G0; req1 only -> G1; both -> the requester not last served; neither -> stay IDLE.
REQ-019 Grant latency SHALL be exactly one cycle: a request sampled in IDLE at edge N is granted in the cycle after edge N.
REQ-020 A hold counter SHALL load 1 on entry to G0/G1 and increment each further cycle in the same state.
REQ-021 Gx SHALL release when the owner's req is low, or when the hold counter equals MAX_HOLD (forced release).
REQ-022 On release, if the other requester's req is high, the FSM SHALL go directly to the other grant state with no IDLE gap; otherwise it SHALL go to IDLE.
REQ-023 After a forced release with only the same requester still requesting, the FSM SHALL spend exactly one cycle in IDLE, then re-grant that requester.
REQ-024 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-025 y_valid(t+1) SHALL equal (gnt0 & req0) | (gnt1 & req1) at cycle t; on that condition y(t+1) = a(t) in G0, b(t) in G1.
REQ-026 When y_valid is not asserted, y SHALL hold its previous value.
REQ-027 Requests deasserted and reasserted in the same cycle as a release SHALL be evaluated using the values sampled at that edge only.

Reset
REQ-028 With reset high at a clock edge: state = IDLE, gnt0 = gnt1 = 0, busy = 0, sel = 0, y = 0, y_valid = 0, hold counter = 0, last-served = 1.
REQ-029 Reset SHALL take priority over all other inputs, including mid-tenure; the grant drops on the first edge with reset high.
REQ-030 The first grant after reset release SHALL follow REQ-018/REQ-019 with no extra wait.

Verification
REQ-031 Reset, then req0=1, a=32'h0000_00A5 held -> gnt0=1 one cycle later, sel=0, y=32'h0000_00A5 and y_valid=1 the following cycle.
REQ-032 req0=req1=1 from reset, MAX_HOLD=8 -> grant order G0 for 8 cycles, G1 for 8 cycles, G0 for 8 cycles, no IDLE cycle between tenures, never both grants high.
REQ-033 Only req1 held continuously, MAX_HOLD=4 -> gnt1 high 4 cycles, low 1 cycle (IDLE), high 4 cycles, repeating; y_valid follows gnt1 delayed by one cycle.
REQ-034 G0 active, req0 drops while req1=1, b=32'hDEAD_BEEF -> next cycle gnt1=1, sel=1; cycle after, y=32'hDEAD_BEEF, y_valid=1.
REQ-035 Reset asserted in the 3rd cycle of a G1 tenure -> following cycle gnt1=0, sel=0, y=0, y_valid=0; with both requests still high after reset drops, requester 0 is granted first.
REQ-036 Random req0/req1/a/b for 10,000 cycles against a reference model -> outputs match every cycle, tenure never exceeds MAX_HOLD, mutual exclusion holds.

Source files
------------

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester arbiter driving a registered 2:1 operand mux
module mux_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [1:0] state;
    logic [1:0] state_n;
    logic [7:0] hold;
    logic       last;
    logic       capture;

    // On release the other requester is served back-to-back; otherwise fall to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req0 && req1)  state_n = last ? G0 : G1;
                else if (req0)     state_n = G0;
                else if (req1)     state_n = G1;
            end
            G0: begin
                if (!req0 || hold == HOLD_LIMIT) state_n = req1 ? G1 : IDLE;
            end
            G1: begin
                if (!req1 || hold == HOLD_LIMIT) state_n = req0 ? G0 : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign capture = (state == G0 && req0) || (state == G1 && req1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hold    <= 8'd0;
            last    <= 1'b1;
            sel     <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == IDLE)       hold <= 8'd0;
            else if (state_n == state) hold <= hold + 8'd1;
            else                       hold <= 8'd1;
            if (state_n == G0) begin
                last <= 1'b0;
                sel  <= 1'b0;
            end else if (state_n == G1) begin
                last <= 1'b1;
                sel  <= 1'b1;
            end
            y_valid <= capture;
            if (capture) y <= (state == G1) ? b : a;
        end
    end

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);
    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - randomized and directed checks of mux_arbiter at MAX_HOLD 8 and 4
module tb_mux_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset, req0, req1;
    logic [W-1:0] a, b;
    logic gnt0_w[2], gnt1_w[2], sel_w[2], yv_w[2], busy_w[2];
    logic [W-1:0] y_w[2];

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .a(a), .b(b),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .sel(sel_w[0]), .y(y_w[0]),
        .y_valid(yv_w[0]), .busy(busy_w[0]));

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .a(a), .b(b),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .sel(sel_w[1]), .y(y_w[1]),
        .y_valid(yv_w[1]), .busy(busy_w[1]));

    int checks = 0;
    int errors = 0;
    int maxh[2] = '{8, 4};
    int m_owner[2], m_ten[2], m_last[2], run[2], prev_owner[2];
    logic m_sel[2], m_yv[2];
    logic [W-1:0] m_y[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner is -1 when nobody holds the path; tenure counts cycles of the current grant.
    task automatic model_step(input int i);
        int nxt, mine, other;
        if (reset) begin
            m_owner[i] = -1; m_ten[i] = 0; m_last[i] = 1;
            m_sel[i] = 1'b0; m_y[i] = '0; m_yv[i] = 1'b0;
            return;
        end
        if ((m_owner[i] == 0 && req0) || (m_owner[i] == 1 && req1)) begin
            m_yv[i] = 1'b1;
            m_y[i]  = (m_owner[i] == 0) ? a : b;
        end else begin
            m_yv[i] = 1'b0;
        end
        if (m_owner[i] < 0) begin
            if (req0 && req1) nxt = 1 - m_last[i];
            else if (req0)    nxt = 0;
            else if (req1)    nxt = 1;
            else              nxt = -1;
        end else begin
            mine  = (m_owner[i] == 0) ? int'(req0) : int'(req1);
            other = (m_owner[i] == 0) ? int'(req1) : int'(req0);
            if (mine != 0 && m_ten[i] < maxh[i]) nxt = m_owner[i];
            else if (other != 0)                 nxt = 1 - m_owner[i];
            else                                 nxt = -1;
        end
        if (nxt < 0) begin
            m_owner[i] = -1; m_ten[i] = 0;
        end else if (nxt == m_owner[i]) begin
            m_ten[i]++;
        end else begin
            m_owner[i] = nxt; m_ten[i] = 1; m_last[i] = nxt; m_sel[i] = nxt[0];
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            int own;
            s = (i == 0) ? "h8" : "h4";
            check({s, ".gnt0"},   gnt0_w[i], m_owner[i] == 0);
            check({s, ".gnt1"},   gnt1_w[i], m_owner[i] == 1);
            check({s, ".busy"},   busy_w[i], m_owner[i] >= 0);
            check({s, ".sel"},    sel_w[i],  m_sel[i]);
            check({s, ".y_valid"}, yv_w[i],  m_yv[i]);
            check({s, ".y"},      y_w[i],    m_y[i]);
            check({s, ".mutex"},  gnt0_w[i] & gnt1_w[i], 1'b0);
            own = gnt0_w[i] ? 0 : (gnt1_w[i] ? 1 : -1);
            if (own >= 0 && own == prev_owner[i]) run[i]++;
            else if (own >= 0) run[i] = 1;
            else run[i] = 0;
            prev_owner[i] = own;
            check({s, ".tenure_le_max"}, run[i] <= maxh[i], 1'b1);
        end
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic rs);
        reset = rs; req0 = r0; req1 = r1; a = av; b = bv;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; prev_owner[i] = -1;
            m_owner[i] = -1; m_ten[i] = 0; m_last[i] = 1;
            m_sel[i] = 1'b0; m_yv[i] = 1'b0; m_y[i] = '0;
        end
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; a = '0; b = '0;

        cyc(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        check("reset_gnt0", gnt0_w[0], 1'b0);
        check("reset_y", y_w[0], 32'h0);

        cyc(1'b1, 1'b0, 32'h0000_00A5, '0, 1'b0);
        check("first_grant_gnt0", gnt0_w[0], 1'b1);
        check("first_grant_sel", sel_w[0], 1'b0);
        cyc(1'b1, 1'b0, 32'h0000_00A5, '0, 1'b0);
        check("first_capture_y", y_w[0], 32'h0000_00A5);
        check("first_capture_valid", yv_w[0], 1'b1);

        cyc(1'b0, 1'b1, '0, 32'hDEAD_BEEF, 1'b0);
        check("handover_gnt1", gnt1_w[0], 1'b1);
        check("handover_sel", sel_w[0], 1'b1);
        cyc(1'b0, 1'b1, '0, 32'hDEAD_BEEF, 1'b0);
        check("handover_y", y_w[0], 32'hDEAD_BEEF);
        check("handover_valid", yv_w[0], 1'b1);
        cyc(1'b1, 1'b1, '0, 32'hDEAD_BEEF, 1'b0);
        check("g1_third_cycle", gnt1_w[0], 1'b1);
        cyc(1'b1, 1'b1, '0, 32'hDEAD_BEEF, 1'b1);
        check("midtenure_reset_gnt1", gnt1_w[0], 1'b0);
        check("midtenure_reset_sel", sel_w[0], 1'b0);
        check("midtenure_reset_y", y_w[0], 32'h0);
        check("midtenure_reset_valid", yv_w[0], 1'b0);

        // Both requesting from reset: tenures alternate every MAX_HOLD cycles with no gap.
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b1, 32'(k), 32'(k + 100), 1'b0);
            check($sformatf("rr8_gnt0_k%0d", k), gnt0_w[0], ((k / 8) % 2) == 0);
            check($sformatf("rr8_gnt1_k%0d", k), gnt1_w[0], ((k / 8) % 2) == 1);
            check($sformatf("rr4_gnt0_k%0d", k), gnt0_w[1], ((k / 4) % 2) == 0);
        end

        // Lone requester 1: MAX_HOLD grant cycles, then exactly one idle cycle.
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1, '0, 32'(k), 1'b0);
            check($sformatf("solo4_gnt1_k%0d", k), gnt1_w[1], (k % 5) < 4);
            check($sformatf("solo4_valid_k%0d", k), yv_w[1], k > 0 && ((k - 1) % 5) < 4);
            check($sformatf("solo8_gnt1_k%0d", k), gnt1_w[0], (k % 9) < 8);
        end

        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        for (int n = 0; n < 10000; n++) begin
            logic r0, r1, rs;
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 499) == 0);
            cyc(r0, r1, $urandom, $urandom, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
